// File: rtl/fwrisc_uart_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : fwrisc_uart_program_loader
// Purpose  : Packs UART program bytes little-endian into 32-bit instruction
//            RAM words and holds the fwrisc core in reset until the image
//            has been fully written.
// Revision : 1.0  initial release
// ============================================================================
module fwrisc_uart_program_loader #(
    parameter int PROG_BYTES    = 4096,
    parameter int ADDR_WIDTH    = 10,
    parameter int RELEASE_DELAY = 16
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic [7:0]                    rx_data,
    input  logic                          rx_valid,
    input  logic                          rx_err,
    output logic                          mem_we,
    output logic [ADDR_WIDTH-1:0]         mem_addr,
    output logic [31:0]                   mem_wdata,
    output logic                          program_receiving,
    output logic                          program_done,
    output logic                          program_ov,
    output logic                          program_err,
    output logic                          core_reset,
    output logic [$clog2(PROG_BYTES):0]   byte_count
);

    localparam int c_CNT_W = $clog2(PROG_BYTES) + 1;
    localparam int c_DLY_W = (RELEASE_DELAY > 1) ? $clog2(RELEASE_DELAY) : 1;
    localparam logic [c_CNT_W-1:0] c_FULL     = c_CNT_W'(PROG_BYTES);
    localparam logic [c_DLY_W-1:0] c_DLY_INIT = c_DLY_W'(RELEASE_DELAY - 1);

    typedef enum logic [1:0] {
        S_LOAD      = 2'd0,
        S_DONE_WAIT = 2'd1,
        S_RUN       = 2'd2
    } state_t;

    state_t               r_state;
    state_t               w_state_next;

    logic [23:0]          r_asm;
    logic [c_CNT_W-1:0]   r_byte_count;
    logic [c_DLY_W-1:0]   r_dly;
    logic                 r_mem_we;
    logic [ADDR_WIDTH-1:0] r_mem_addr;
    logic [31:0]          r_mem_wdata;
    logic                 r_prog_recv;
    logic                 r_done;
    logic                 r_ov;
    logic                 r_err;
    logic                 r_core_reset;

    logic                 w_clean;
    logic                 w_full;
    logic                 w_accept;
    logic                 w_overflow;
    logic                 w_finish;
    logic                 w_release;
    logic [1:0]           w_lane;

    assign w_clean = rx_valid && !rx_err;
    assign w_full  = (r_byte_count == c_FULL);
    assign w_lane  = r_byte_count[1:0];

    always_ff @(posedge clock) begin
        if (reset) begin
            r_state <= S_LOAD;
        end else begin
            r_state <= w_state_next;
        end
    end

    // The image completes in the cycle its final word is on the RAM port,
    // so program_done becomes visible one cycle after that write.
    always_comb begin
        w_state_next = r_state;
        w_accept     = 1'b0;
        w_overflow   = 1'b0;
        w_finish     = 1'b0;
        w_release    = 1'b0;
        case (r_state)
            S_LOAD: begin
                w_accept   = w_clean && !w_full;
                w_overflow = w_clean && w_full;
                if (r_mem_we && w_full) begin
                    w_finish     = 1'b1;
                    w_state_next = S_DONE_WAIT;
                end
            end
            S_DONE_WAIT: begin
                w_overflow = w_clean;
                if (r_dly == '0) begin
                    w_release    = 1'b1;
                    w_state_next = S_RUN;
                end
            end
            S_RUN: begin
                w_overflow = w_clean;
            end
            default: begin
                w_state_next = S_LOAD;
            end
        endcase
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            r_asm        <= '0;
            r_byte_count <= '0;
            r_dly        <= '0;
            r_mem_we     <= 1'b0;
            r_mem_addr   <= '0;
            r_mem_wdata  <= '0;
            r_prog_recv  <= 1'b0;
            r_done       <= 1'b0;
            r_ov         <= 1'b0;
            r_err        <= 1'b0;
            r_core_reset <= 1'b1;
        end else begin
            r_mem_we    <= 1'b0;
            r_prog_recv <= w_accept;

            if (w_accept) begin
                r_byte_count <= r_byte_count + c_CNT_W'(1);
                // Lane 3 bypasses the assembly register straight into the
                // write-data register, leaving lanes 0-2 free for the next word.
                case (w_lane)
                    2'd0: r_asm[7:0]   <= rx_data;
                    2'd1: r_asm[15:8]  <= rx_data;
                    2'd2: r_asm[23:16] <= rx_data;
                    default: begin
                        r_mem_we    <= 1'b1;
                        r_mem_addr  <= ADDR_WIDTH'(r_byte_count >> 2);
                        r_mem_wdata <= {rx_data, r_asm};
                    end
                endcase
            end

            if (rx_valid && rx_err) begin
                r_err <= 1'b1;
            end
            if (w_overflow) begin
                r_ov <= 1'b1;
            end

            if (w_finish) begin
                r_done <= 1'b1;
                r_dly  <= c_DLY_INIT;
            end else if ((r_state == S_DONE_WAIT) && (r_dly != '0)) begin
                r_dly <= r_dly - c_DLY_W'(1);
            end

            if (w_release) begin
                r_core_reset <= 1'b0;
            end
        end
    end

    assign mem_we            = r_mem_we;
    assign mem_addr          = r_mem_addr;
    assign mem_wdata         = r_mem_wdata;
    assign program_receiving = r_prog_recv;
    assign program_done      = r_done;
    assign program_ov        = r_ov;
    assign program_err       = r_err;
    assign core_reset        = r_core_reset;
    assign byte_count        = r_byte_count;

endmodule
`default_nettype wire

// File: tb/tb_fwrisc_uart_program_loader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fwrisc_uart_program_loader
// Purpose  : Bench for the UART program loader: an 8-byte image instance and
//            a default 4096-byte instance, checked against a byte-level model.
// Revision : 1.0  initial release
// ============================================================================
module tb_fwrisc_uart_program_loader;

    localparam int P0 = 8;
    localparam int P1 = 4096;
    localparam int RD = 16;

    logic clock = 1'b0;
    logic reset;
    always #5 clock = ~clock;

    logic [7:0]  rx_data  [2];
    logic        rx_valid [2];
    logic        rx_err   [2];
    logic        we   [2];
    logic [9:0]  addr [2];
    logic [31:0] wd   [2];
    logic        recv [2];
    logic        done [2];
    logic        ov   [2];
    logic        err  [2];
    logic        crst [2];
    logic [3:0]  bc0;
    logic [12:0] bc1;

    fwrisc_uart_program_loader #(.PROG_BYTES(P0), .ADDR_WIDTH(10), .RELEASE_DELAY(RD)) dut_s (
        .clock(clock), .reset(reset),
        .rx_data(rx_data[0]), .rx_valid(rx_valid[0]), .rx_err(rx_err[0]),
        .mem_we(we[0]), .mem_addr(addr[0]), .mem_wdata(wd[0]),
        .program_receiving(recv[0]), .program_done(done[0]), .program_ov(ov[0]),
        .program_err(err[0]), .core_reset(crst[0]), .byte_count(bc0)
    );

    fwrisc_uart_program_loader dut_l (
        .clock(clock), .reset(reset),
        .rx_data(rx_data[1]), .rx_valid(rx_valid[1]), .rx_err(rx_err[1]),
        .mem_we(we[1]), .mem_addr(addr[1]), .mem_wdata(wd[1]),
        .program_receiving(recv[1]), .program_done(done[1]), .program_ov(ov[1]),
        .program_err(err[1]), .core_reset(crst[1]), .byte_count(bc1)
    );

    int total = 0;
    int bad   = 0;
    logic chk_en = 1'b0;

    task automatic chk(input string nm, input int inst, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s[%0d] t=%0t actual=%h required=%h", nm, inst, $time, act, exp);
        end
    endtask

    // Byte-level model: image bytes, accepted count, and the cycle the image
    // completes; all status timing is derived from that completion cycle.
    int          P[2]        = '{P0, P1};
    int          cyc         = 0;
    int          m_cnt[2]    = '{0, 0};
    logic [7:0]  m_img[2][4096];
    logic        m_we[2]     = '{1'b0, 1'b0};
    int          m_addr[2]   = '{0, 0};
    logic [31:0] m_wd[2];
    logic        m_recv[2]   = '{1'b0, 1'b0};
    logic        m_err[2]    = '{1'b0, 1'b0};
    logic        m_ov[2]     = '{1'b0, 1'b0};
    int          done_cyc[2] = '{-1, -1};

    always @(posedge clock) begin
        cyc = cyc + 1;
        for (int i = 0; i < 2; i++) begin
            m_we[i]   = 1'b0;
            m_recv[i] = 1'b0;
            if (reset) begin
                m_cnt[i]    = 0;
                m_err[i]    = 1'b0;
                m_ov[i]     = 1'b0;
                done_cyc[i] = -1;
            end else if (rx_valid[i] && rx_err[i]) begin
                m_err[i] = 1'b1;
            end else if (rx_valid[i]) begin
                if (m_cnt[i] < P[i]) begin
                    m_img[i][m_cnt[i]] = rx_data[i];
                    m_cnt[i]  = m_cnt[i] + 1;
                    m_recv[i] = 1'b1;
                    if (m_cnt[i] % 4 == 0) begin
                        m_we[i]   = 1'b1;
                        m_addr[i] = m_cnt[i] / 4 - 1;
                        m_wd[i]   = {m_img[i][m_cnt[i]-1], m_img[i][m_cnt[i]-2],
                                     m_img[i][m_cnt[i]-3], m_img[i][m_cnt[i]-4]};
                        if (m_cnt[i] == P[i]) done_cyc[i] = cyc + 1;
                    end
                end else begin
                    m_ov[i] = 1'b1;
                end
            end
        end
    end

    // Event log used by the literal checks.
    int          rc[2]            = '{0, 0};
    int          wr_cnt[2]        = '{0, 0};
    int          last_addr[2]     = '{0, 0};
    int          last_we_cyc[2]   = '{0, 0};
    int          done_rise_cyc[2] = '{0, 0};
    int          crst_fall_cyc[2] = '{0, 0};
    logic        prev_done[2]     = '{1'b0, 1'b0};
    logic        prev_crst[2]     = '{1'b1, 1'b1};
    int          wr_addr0[$];
    logic [31:0] wr_data0[$];

    always @(negedge clock) begin
        if (chk_en) begin
            for (int i = 0; i < 2; i++) begin
                logic        e_done;
                logic        e_crst;
                logic [31:0] a_bc;
                e_done = (done_cyc[i] >= 0) && (cyc >= done_cyc[i]);
                e_crst = !((done_cyc[i] >= 0) && (cyc >= done_cyc[i] + RD));
                a_bc   = (i == 0) ? 32'(bc0) : 32'(bc1);
                chk("mem_we", i, 32'(we[i]), 32'(m_we[i]));
                chk("program_receiving", i, 32'(recv[i]), 32'(m_recv[i]));
                chk("program_done", i, 32'(done[i]), 32'(e_done));
                chk("program_ov", i, 32'(ov[i]), 32'(m_ov[i]));
                chk("program_err", i, 32'(err[i]), 32'(m_err[i]));
                chk("core_reset", i, 32'(crst[i]), 32'(e_crst));
                chk("byte_count", i, a_bc, 32'(m_cnt[i]));
                if (m_we[i]) begin
                    chk("mem_addr", i, 32'(addr[i]), 32'(m_addr[i]));
                    chk("mem_wdata", i, wd[i], m_wd[i]);
                end
                if (recv[i] === 1'b1) rc[i]++;
                if (we[i] === 1'b1) begin
                    wr_cnt[i]++;
                    last_addr[i]   = int'(addr[i]);
                    last_we_cyc[i] = cyc;
                    if (i == 0) begin
                        wr_addr0.push_back(int'(addr[i]));
                        wr_data0.push_back(wd[i]);
                    end
                end
                if (done[i] === 1'b1 && !prev_done[i]) done_rise_cyc[i] = cyc;
                if (crst[i] === 1'b0 && prev_crst[i]) crst_fall_cyc[i] = cyc;
                prev_done[i] = (done[i] === 1'b1);
                prev_crst[i] = (crst[i] !== 1'b0);
            end
        end
    end

    task automatic send(input int i, input logic [7:0] d, input logic e, input int gap);
        rx_data[i]  = d;
        rx_err[i]   = e;
        rx_valid[i] = 1'b1;
        @(negedge clock);
        rx_valid[i] = 1'b0;
        rx_err[i]   = 1'b0;
        repeat (gap) @(negedge clock);
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rc[i]     = 0;
            wr_cnt[i] = 0;
        end
        wr_addr0.delete();
        wr_data0.delete();
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog t=%0t actual=running required=finished", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] img1 [8];
        img1 = '{8'h13, 8'h00, 8'h00, 8'h00, 8'h6F, 8'h00, 8'h00, 8'h00};
        for (int i = 0; i < 2; i++) begin
            rx_data[i]  = 8'h00;
            rx_valid[i] = 1'b0;
            rx_err[i]   = 1'b0;
        end
        reset = 1'b1;
        repeat (2) @(negedge clock);
        chk_en = 1'b1;
        chk("rst_core_reset", 0, 32'(crst[0]), 32'd1);
        chk("rst_byte_count", 1, 32'(bc1), 32'd0);
        chk("rst_mem_wdata", 0, wd[0], 32'd0);
        reset = 1'b0;
        for (int i = 0; i < 2; i++) begin
            rc[i]     = 0;
            wr_cnt[i] = 0;
        end

        // Spaced 8-byte image.
        foreach (img1[k]) send(0, img1[k], 1'b0, 19);
        repeat (40) @(negedge clock);
        chk("t1_pulses", 0, 32'(rc[0]), 32'd8);
        chk("t1_writes", 0, 32'(wr_cnt[0]), 32'd2);
        chk("t1_w0_addr", 0, 32'(wr_addr0[0]), 32'd0);
        chk("t1_w0_data", 0, wr_data0[0], 32'h00000013);
        chk("t1_w1_addr", 0, 32'(wr_addr0[1]), 32'd1);
        chk("t1_w1_data", 0, wr_data0[1], 32'h0000006F);
        chk("t1_done_lat", 0, 32'(done_rise_cyc[0] - last_we_cyc[0]), 32'd1);
        chk("t1_release_lat", 0, 32'(crst_fall_cyc[0] - done_rise_cyc[0]), 32'd16);

        // Back-to-back bytes, fifth byte lands in the mem_we cycle.
        do_reset();
        send(0, 8'hAA, 1'b0, 0);
        send(0, 8'hBB, 1'b0, 0);
        send(0, 8'hCC, 1'b0, 0);
        send(0, 8'hDD, 1'b0, 0);
        send(0, 8'hEE, 1'b0, 0);
        send(0, 8'h11, 1'b0, 0);
        send(0, 8'h22, 1'b0, 0);
        send(0, 8'h33, 1'b0, 3);
        chk("t2_w0_data", 0, wr_data0[0], 32'hDDCCBBAA);
        chk("t2_w0_addr", 0, 32'(wr_addr0[0]), 32'd0);
        chk("t2_w1_data", 0, wr_data0[1], 32'h332211EE);
        chk("t2_pulses", 0, 32'(rc[0]), 32'd8);

        // Errored lane-2 byte, then resent clean.
        do_reset();
        send(0, 8'h01, 1'b0, 2);
        send(0, 8'h02, 1'b0, 2);
        send(0, 8'h03, 1'b1, 2);
        chk("t4_err_nopulse", 0, 32'(rc[0]), 32'd2);
        chk("t4_err_flag", 0, 32'(err[0]), 32'd1);
        send(0, 8'h03, 1'b0, 2);
        send(0, 8'h04, 1'b0, 2);
        chk("t4_byte_count", 0, 32'(bc0), 32'd4);
        chk("t4_w0_data", 0, wr_data0[0], 32'h04030201);

        // Reset mid-load, then a fresh image.
        do_reset();
        for (int k = 0; k < 6; k++) send(0, 8'(8'hA0 + k), 1'b0, 1);
        do_reset();
        for (int k = 0; k < 8; k++) send(0, 8'(8'h50 + k), 1'b0, 1);
        repeat (30) @(negedge clock);
        chk("t5_writes", 0, 32'(wr_cnt[0]), 32'd2);
        chk("t5_w0_addr", 0, 32'(wr_addr0[0]), 32'd0);
        chk("t5_w0_data", 0, wr_data0[0], 32'h53525150);
        chk("t5_done", 0, 32'(done[0]), 32'd1);

        // Full 4096-byte image plus one overflow byte, paced by the strobe.
        do_reset();
        for (int k = 0; k <= P1; k++) begin
            send(1, 8'(k) ^ 8'(k >> 8), 1'b0, 0);
            if (k < P1) begin
                int w;
                w = 0;
                while (recv[1] !== 1'b1 && w < 8) begin
                    @(negedge clock);
                    w++;
                end
                chk("t3_pace", 1, 32'(recv[1]), 32'd1);
            end
        end
        repeat (RD + 5) @(negedge clock);
        chk("t3_writes", 1, 32'(wr_cnt[1]), 32'd1024);
        chk("t3_last_addr", 1, 32'(last_addr[1]), 32'd1023);
        chk("t3_done", 1, 32'(done[1]), 32'd1);
        chk("t3_ov", 1, 32'(ov[1]), 32'd1);
        chk("t3_byte_count", 1, 32'(bc1), 32'd4096);
        chk("t3_core_reset", 1, 32'(crst[1]), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire
